// File: rtl/rand_pkg.sv
// Shared types and helpers for the pseudo-random draw register.
package rand_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-shifting Galois masks giving maximal-length sequences, zero-extended to 32 bits.
  function automatic logic [31:0] default_taps(input int unsigned w);
    case (w)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

  // One Galois step; narrower states are zero-extended so the upper bits stay zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/gen_reg_n.sv
// Generic WIDTH-bit register with clock enable and asynchronous active-low clear.
module gen_reg_n #(
  parameter int unsigned     WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/rand_draw_reg.sv
// On-request pseudo-random draw: mixes a Galois LFSR STEPS times, then holds the result until ack.
module rand_draw_reg
  import rand_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter int unsigned      STEPS    = 8,
  parameter bit               FREE_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy
);

  if (SEED == '0) begin : g_bad_seed
    $error("rand_draw_reg: SEED must be non-zero");
  end
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("rand_draw_reg: WIDTH must be 4..32");
  end
  if (STEPS < 1 || STEPS > 255) begin : g_bad_steps
    $error("rand_draw_reg: STEPS must be 1..255");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] lfsr_nxt_c;

  assign lfsr_nxt_c = WIDTH'(lfsr_step(32'(lfsr_q), 32'(TAPS)));

  // The accept edge performs the first step; the final MIX cycle only captures,
  // so q always holds exactly STEPS steps past the pre-request state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    lfsr_d  = lfsr_q;
    q_d     = q_q;
    if (seed_ld) begin
      lfsr_d  = (seed == '0) ? WIDTH'(1) : seed;
      state_d = IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = MIX;
            cnt_d   = CNT_W'(STEPS - 1);
            busy_d  = 1'b1;
            lfsr_d  = lfsr_nxt_c;
          end else if (FREE_RUN) begin
            lfsr_d = lfsr_nxt_c;
          end
        end
        MIX: begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_W'(1);
            lfsr_d = lfsr_nxt_c;
          end else begin
            q_d     = lfsr_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          if (ack) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
          if (FREE_RUN) begin
            lfsr_d = lfsr_nxt_c;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  gen_reg_n #(.WIDTH(WIDTH), .RST_VAL(SEED)) u_lfsr_reg (
    .clk   (clk),
    .clr_n (clr_n),
    .en_i  (en),
    .d_i   (lfsr_d),
    .q_o   (lfsr_q)
  );

  gen_reg_n #(.WIDTH(WIDTH), .RST_VAL('0)) u_q_reg (
    .clk   (clk),
    .clr_n (clr_n),
    .en_i  (en),
    .d_i   (q_d),
    .q_o   (q_q)
  );

  assign q     = q_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rand_draw_reg.sv
// Scenario bench for rand_draw_reg: three configurations share stimulus, expected draws come from a queue.
module tb_rand_draw_reg;

  logic       clk = 1'b0;
  logic       clr_n, en, seed_ld, req, ack;
  logic [7:0] seed;
  logic [7:0] q8, q1, qf;
  logic       v8, b8, v1, b1, vf, bf;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rand_draw_reg #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(8), .FREE_RUN(1'b0)) u_dut8 (
    .clk(clk), .clr_n(clr_n), .en(en), .seed_ld(seed_ld), .seed(seed),
    .req(req), .ack(ack), .q(q8), .valid(v8), .busy(b8)
  );

  rand_draw_reg #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .FREE_RUN(1'b0)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .en(en), .seed_ld(seed_ld), .seed(seed),
    .req(req), .ack(ack), .q(q1), .valid(v1), .busy(b1)
  );

  rand_draw_reg #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1), .FREE_RUN(1'b1)) u_dutfr (
    .clk(clk), .clr_n(clr_n), .en(en), .seed_ld(seed_ld), .seed(seed),
    .req(req), .ack(ack), .q(qf), .valid(vf), .busy(bf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_v(input int sel);
    case (sel)
      0:       return v8;
      1:       return v1;
      default: return vf;
    endcase
  endfunction

  function automatic logic [7:0] pop_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic wait_valid(input int sel, input int budget, output int cyc);
    cyc = 0;
    while (get_v(sel) !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset;
    en = 1'b1; seed_ld = 1'b0; seed = 8'h00; req = 1'b0; ack = 1'b0;
    clr_n = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  task automatic pulse_req;
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (q8 !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", q8); end
    n_cmp++; if (v8 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", v8); end
    n_cmp++; if (b8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", b8); end
  endtask

  task automatic test_basic_draw;
    int cyc;
    int busy_cnt;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'h64);
    pulse_req();
    cyc = 0;
    busy_cnt = 0;
    while (v8 !== 1'b1 && cyc < 50) begin
      if (b8 === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    e = pop_exp();
    n_cmp++; if (cyc != 8) begin n_bad++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    n_cmp++; if (busy_cnt != 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
    n_cmp++; if (b8 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", b8); end
    n_cmp++; if (q8 !== e) begin n_bad++; $display("FAIL basic_q: got %h want %h", q8, e); end
    repeat (3) tick();
    n_cmp++; if (v8 !== 1'b1 || q8 !== e) begin
      n_bad++; $display("FAIL basic_hold: got valid=%b q=%h want valid=1 q=%h", v8, q8, e);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (v8 !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got valid=%b want 0", v8); end
  endtask

  task automatic test_steps1;
    int cyc;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'hB8);
    pulse_req();
    wait_valid(1, 20, cyc);
    e = pop_exp();
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL steps1_latency: got %0d want 1", cyc); end
    n_cmp++; if (q1 !== e) begin n_bad++; $display("FAIL steps1_q0: got %h want %h", q1, e); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL steps1_ack: got %b want 0", v1); end
    exp_q.push_back(8'h5C);
    pulse_req();
    wait_valid(1, 20, cyc);
    e = pop_exp();
    n_cmp++; if (q1 !== e) begin n_bad++; $display("FAIL steps1_q1: got %h want %h", q1, e); end
    req = 1'b1; ack = 1'b1;
    tick();
    req = 1'b0; ack = 1'b0;
    n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL steps1_req_ack: got valid=%b want 0", v1); end
    repeat (3) tick();
    n_cmp++; if (v1 !== 1'b0 || b1 !== 1'b0) begin
      n_bad++; $display("FAIL steps1_req_ignored: got valid=%b busy=%b want 0/0", v1, b1);
    end
  endtask

  task automatic test_seed_ld;
    int cyc;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'hB8);
    pulse_req();
    wait_valid(1, 20, cyc);
    e = pop_exp();
    n_cmp++; if (q1 !== e) begin n_bad++; $display("FAIL seed_pre: got %h want %h", q1, e); end
    ack = 1'b1; tick(); ack = 1'b0;
    seed_ld = 1'b1; seed = 8'h00; tick(); seed_ld = 1'b0;
    exp_q.push_back(8'hB8);
    pulse_req();
    wait_valid(1, 20, cyc);
    e = pop_exp();
    n_cmp++; if (q1 !== e) begin n_bad++; $display("FAIL seed_zero: got %h want %h", q1, e); end

    do_reset();
    exp_q.push_back(8'h64);
    pulse_req();
    wait_valid(0, 50, cyc);
    e = pop_exp();
    n_cmp++; if (q8 !== e) begin n_bad++; $display("FAIL seed_first_draw: got %h want %h", q8, e); end
    ack = 1'b1; tick(); ack = 1'b0;
    pulse_req();
    tick();
    tick();
    n_cmp++; if (b8 !== 1'b1) begin n_bad++; $display("FAIL seed_mid_mix: got busy=%b want 1", b8); end
    seed_ld = 1'b1; seed = 8'h17; tick(); seed_ld = 1'b0; seed = 8'h00;
    n_cmp++; if (b8 !== 1'b0 || v8 !== 1'b0) begin
      n_bad++; $display("FAIL seed_abort: got busy=%b valid=%b want 0/0", b8, v8);
    end
    n_cmp++; if (q8 !== 8'h64) begin n_bad++; $display("FAIL seed_q_kept: got %h want 64", q8); end
    exp_q.push_back(8'hB3);
    pulse_req();
    n_cmp++; if (b8 !== 1'b1) begin n_bad++; $display("FAIL seed_idle_accept: got busy=%b want 1", b8); end
    wait_valid(1, 20, cyc);
    e = pop_exp();
    n_cmp++; if (q1 !== e) begin n_bad++; $display("FAIL seed_17_draw: got %h want %h", q1, e); end
  endtask

  task automatic test_enable;
    int cyc;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'h64);
    pulse_req();
    cyc = 0;
    repeat (2) begin tick(); cyc++; end
    en = 1'b0;
    repeat (5) begin tick(); cyc++; end
    en = 1'b1;
    while (v8 !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    e = pop_exp();
    n_cmp++; if (cyc != 13) begin n_bad++; $display("FAIL en_latency: got %0d want 13", cyc); end
    n_cmp++; if (q8 !== e) begin n_bad++; $display("FAIL en_q: got %h want %h", q8, e); end
    en = 1'b0; ack = 1'b1;
    tick();
    tick();
    n_cmp++; if (v8 !== 1'b1 || q8 !== e) begin
      n_bad++; $display("FAIL en_frozen_done: got valid=%b q=%h want 1/%h", v8, q8, e);
    end
    en = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (v8 !== 1'b0) begin n_bad++; $display("FAIL en_ack_after: got %b want 0", v8); end
  endtask

  task automatic test_async_clear;
    int cyc;
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'h64);
    pulse_req();
    wait_valid(0, 50, cyc);
    e = pop_exp();
    n_cmp++; if (q8 !== e) begin n_bad++; $display("FAIL clr_pre: got %h want %h", q8, e); end
    #2 clr_n = 1'b0;
    #1;
    n_cmp++; if (q8 !== 8'h00 || v8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_async: got q=%h valid=%b want 00/0", q8, v8);
    end
    #1 clr_n = 1'b1;
    tick();
    exp_q.push_back(8'h64);
    pulse_req();
    wait_valid(0, 50, cyc);
    e = pop_exp();
    n_cmp++; if (q8 !== e) begin n_bad++; $display("FAIL clr_redraw: got %h want %h", q8, e); end
  endtask

  task automatic test_free_run;
    int cyc;
    logic [7:0] e;
    do_reset();
    repeat (3) tick();
    exp_q.push_back(8'h17);
    pulse_req();
    wait_valid(2, 20, cyc);
    e = pop_exp();
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL fr_latency: got %0d want 1", cyc); end
    n_cmp++; if (qf !== e) begin n_bad++; $display("FAIL fr_q: got %h want %h", qf, e); end
  endtask

  initial begin
    test_reset();
    test_basic_draw();
    test_steps1();
    test_seed_ld();
    test_enable();
    test_async_clear();
    test_free_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
